// File: rtl/chan_packet_pkg.sv
// chan_packet_pkg: shared magic words, FSM state encoding and register field positions for the framer
package chan_packet_pkg;
   localparam logic [7:0] HDR_MAGIC = 8'hA5;
   localparam logic [7:0] TRL_MAGIC = 8'h5A;
   localparam int EN_BIT   = 0;
   localparam int TRIG_BIT = 1;
   localparam int TAG_LSB  = 8;
   localparam int LEN_LSB  = 16;
   typedef enum logic [2:0] {IDLE, HDR, SYNC, PAY, TRL} state_t;
endpackage

// File: rtl/chan_packet_out_reg.sv
// chan_packet_out_reg: one-entry valid/ready holding register driving the packet output
module chan_packet_out_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_load,
   input  logic [W-1:0] i_data,
   input  logic         i_last,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [W-1:0] o_data,
   output logic         o_last,
   output logic         o_can_load,
   output logic         o_accept
);
   logic         r_valid;
   logic         r_last;
   logic [W-1:0] r_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
         r_last  <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
         r_last  <= i_last;
      end else if (o_accept) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
      end
   end
   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_last     = r_last;
   assign o_accept   = r_valid & i_ready;
   assign o_can_load = ~r_valid | i_ready;
endmodule

// File: rtl/chan_packet_framer.sv
// chan_packet_framer: frames the sample stream into header/payload/trailer packets under register control
module chan_packet_framer
   import chan_packet_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 12
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic [31:0]       stb_en_reg,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sync,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   input  logic              out_ready,
   output logic              busy,
   output logic [15:0]       pkt_count,
   output logic [15:0]       drop_count
);
   state_t            r_state, w_state_n;
   logic              r_trig_q, r_cont;
   logic [LEN_W-1:0]  r_len, r_cnt;
   logic [7:0]        r_tag;
   logic [15:0]       r_seq, r_pkt, r_drop, r_pkt_drops;
   logic              w_en, w_rise, w_start, w_again, w_unused;
   logic [7:0]        w_tag;
   logic [LEN_W-1:0]  w_len;
   logic              w_load, w_load_last, w_latch, w_drop, w_done, w_cnt_inc;
   logic [DATA_W-1:0] w_load_data;
   logic              w_can_load, w_accept, w_trl_held;

   assign w_en       = stb_en_reg[EN_BIT];
   assign w_rise     = stb_en_reg[TRIG_BIT] & ~r_trig_q;
   assign w_tag      = stb_en_reg[TAG_LSB +: 8];
   assign w_len      = stb_en_reg[LEN_LSB +: LEN_W];
   assign w_unused   = ^{stb_en_reg[31:28], stb_en_reg[7:2]};
   assign w_start    = (w_len != '0) && (w_en || w_rise);
   assign w_again    = r_cont && w_en && (w_len != '0);
   assign w_trl_held = out_valid && out_last;

   always_comb begin
      w_state_n   = r_state;
      w_load      = 1'b0;
      w_load_data = '0;
      w_load_last = 1'b0;
      w_latch     = 1'b0;
      w_drop      = 1'b0;
      w_done      = 1'b0;
      w_cnt_inc   = 1'b0;
      case (r_state)
         IDLE: begin
            w_latch   = w_start;
            w_state_n = w_start ? HDR : IDLE;
         end
         HDR: begin
            if (!out_valid) begin
               w_load      = 1'b1;
               w_load_data = {HDR_MAGIC, r_tag, r_seq};
            end else if (w_accept) w_state_n = SYNC;
         end
         SYNC: begin
            if (in_valid && in_sync) begin
               w_load      = 1'b1;
               w_load_data = in_data;
               w_state_n   = (r_len == LEN_W'(1)) ? TRL : PAY;
            end
         end
         PAY: begin
            // every valid sample uses a slot, whether it is kept or dropped
            if (in_valid) begin
               w_load      = w_can_load;
               w_load_data = in_data;
               w_drop      = ~w_can_load;
               w_cnt_inc   = 1'b1;
               w_state_n   = (r_cnt == r_len - 1'b1) ? TRL : PAY;
            end
         end
         TRL: begin
            if (!w_trl_held) begin
               w_load      = w_can_load;
               w_load_data = {TRL_MAGIC, 8'h00, r_pkt_drops};
               w_load_last = 1'b1;
            end else if (w_accept) begin
               w_done      = 1'b1;
               w_latch     = w_again;
               w_load      = w_again;
               w_load_data = {HDR_MAGIC, w_tag, r_seq + 16'd1};
               w_state_n   = w_again ? HDR : IDLE;
            end
         end
         default: w_state_n = IDLE;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         r_state     <= IDLE;
         r_trig_q    <= 1'b0;
         r_cont      <= 1'b0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_tag       <= '0;
         r_seq       <= '0;
         r_pkt       <= '0;
         r_drop      <= '0;
         r_pkt_drops <= '0;
      end else begin
         r_state  <= w_state_n;
         r_trig_q <= stb_en_reg[TRIG_BIT];
         if (w_latch) begin
            r_len  <= w_len;
            r_tag  <= w_tag;
            r_cont <= w_en;
         end
         if (r_state == SYNC) r_cnt <= LEN_W'(1);
         else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
         if (w_drop) begin
            r_drop      <= (r_drop == 16'hFFFF) ? r_drop : r_drop + 1'b1;
            r_pkt_drops <= (r_pkt_drops == 16'hFFFF) ? r_pkt_drops : r_pkt_drops + 1'b1;
         end
         if (w_done) begin
            r_pkt       <= r_pkt + 1'b1;
            r_seq       <= r_seq + 1'b1;
            r_pkt_drops <= '0;
         end
      end
   end

   chan_packet_out_reg #(.W(DATA_W)) u_out (
      .clk        (user_clk),
      .rst        (user_rst),
      .i_load     (w_load),
      .i_data     (w_load_data),
      .i_last     (w_load_last),
      .i_ready    (out_ready),
      .o_valid    (out_valid),
      .o_data     (out_data),
      .o_last     (out_last),
      .o_can_load (w_can_load),
      .o_accept   (w_accept)
   );

   assign busy       = (r_state != IDLE);
   assign pkt_count  = r_pkt;
   assign drop_count = r_drop;
endmodule

// File: tb/tb_chan_packet_framer.sv
// tb_chan_packet_framer: scenario-driven bench comparing accepted output words against packets built from the framing rules
module tb_chan_packet_framer;
   logic        user_clk = 1'b0;
   logic        user_rst = 1'b1;
   logic [31:0] stb_en_reg = '0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_sync = 1'b0;
   logic        out_ready = 1'b1;
   logic        out_valid, out_last, busy;
   logic [31:0] out_data;
   logic [15:0] pkt_count, drop_count;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] seq = '0;
   logic [32:0] cap[$];
   logic [32:0] exp_q[$];

   always #5 user_clk = ~user_clk;

   chan_packet_framer dut (
      .user_clk   (user_clk),
      .user_rst   (user_rst),
      .stb_en_reg (stb_en_reg),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_sync    (in_sync),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_last   (out_last),
      .out_ready  (out_ready),
      .busy       (busy),
      .pkt_count  (pkt_count),
      .drop_count (drop_count)
   );

   // a word is delivered when valid and ready are both high at the coming edge
   always @(negedge user_clk) if (!user_rst && out_valid && out_ready) cap.push_back({out_last, out_data});

   function automatic logic [31:0] mk_reg(input logic en, input logic trig, input logic [7:0] tag, input logic [11:0] n);
      return {4'h0, n, tag, 6'h00, trig, en};
   endfunction

   function automatic logic [32:0] hdr(input logic [7:0] tag, input logic [15:0] s);
      return {1'b0, 8'hA5, tag, s};
   endfunction

   function automatic logic [32:0] trl(input logic [15:0] d);
      return {1'b1, 8'h5A, 8'h00, d};
   endfunction

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [31:0] d);
      in_valid = v;
      in_sync  = s;
      in_data  = d;
      tick();
   endtask

   task automatic wait_cap(input int n, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         if (cap.size() >= n) ok = 1'b1;
         else tick();
      end
   endtask

   // payload = first n valid samples starting at the first valid+sync after the header
   task automatic feed(input int n, input bit rnd, input logic [31:0] base);
      logic [31:0] d;
      logic        v;
      if (rnd) repeat ($urandom_range(0, 3)) begin
         v = 1'($urandom);
         drive(v, ~v, $urandom);
      end
      for (int i = 0; i < n; i++) begin
         if (rnd && i > 0) repeat ($urandom_range(0, 2)) drive(1'b0, 1'($urandom), $urandom);
         d = rnd ? $urandom : base + 32'(i);
         drive(1'b1, (i == 0) ? 1'b1 : 1'($urandom), d);
         exp_q.push_back({1'b0, d});
      end
      repeat (2) drive(1'b1, 1'b1, $urandom);
      drive(1'b0, 1'b0, '0);
   endtask

   task automatic test_reset();
      user_rst = 1'b1;
      stb_en_reg = '0;
      repeat (2) tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      n_tests++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset out_last got %b want 0", out_last); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy); end
      n_tests++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset out_data got %h want 0", out_data); end
      n_tests++; if (pkt_count !== 16'h0) begin n_fail++; $display("FAIL reset pkt_count got %h want 0", pkt_count); end
      n_tests++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset drop_count got %h want 0", drop_count); end
      user_rst = 1'b0;
      seq = '0;
   endtask

   task automatic test_basic();
      bit          ok;
      logic [32:0] got;
      cap.delete();
      exp_q.delete();
      stb_en_reg = mk_reg(1'b1, 1'b0, 8'h3C, 12'd4);
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic hdr_early got %b want 0", out_valid); end
      tick();
      n_tests++; if ({out_valid, out_data} !== {1'b1, 32'hA53C0000}) begin n_fail++; $display("FAIL basic hdr_time got %b/%h want 1/a53c0000", out_valid, out_data); end
      exp_q.push_back(hdr(8'h3C, 16'd0));
      wait_cap(1, ok);
      feed(4, 1'b0, 32'h10);
      exp_q.push_back(trl(16'd0));
      exp_q.push_back(hdr(8'h3C, 16'd1));
      wait_cap(exp_q.size(), ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL basic hdr1_timeout got %0d words want %0d", cap.size(), exp_q.size()); end
      stb_en_reg = mk_reg(1'b0, 1'b0, 8'h3C, 12'd4);
      feed(4, 1'b1, '0);
      exp_q.push_back(trl(16'd0));
      wait_cap(exp_q.size(), ok);
      repeat (6) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < cap.size()) ? cap[i] : 'x;
         n_tests++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL basic word%0d got %h want %h", i, got, exp_q[i]); end
      end
      n_tests++; if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL basic count got %0d want %0d", cap.size(), exp_q.size()); end
      n_tests++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL basic pkt_count got %0d want 2", pkt_count); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic busy got %b want 0", busy); end
      seq = 16'd2;
   endtask

   // continuous packets with register changes landing mid-packet; enable drops during the last one
   task automatic test_random();
      bit          ok;
      logic [32:0] got;
      logic [7:0]  tag, ntag;
      logic [11:0] n, nn;
      cap.delete();
      exp_q.delete();
      tag = 8'($urandom);
      n = 12'($urandom_range(1, 6));
      stb_en_reg = mk_reg(1'b1, 1'b0, tag, n);
      for (int p = 0; p < 4; p++) begin
         exp_q.push_back(hdr(tag, seq + 16'(p)));
         wait_cap(exp_q.size(), ok);
         n_tests++; if (!ok) begin n_fail++; $display("FAIL random hdr%0d_timeout got %0d words want %0d", p, cap.size(), exp_q.size()); end
         ntag = 8'($urandom);
         nn = 12'($urandom_range(1, 6));
         stb_en_reg = mk_reg(p < 3, 1'b0, ntag, nn);
         feed(int'(n), 1'b1, '0);
         exp_q.push_back(trl(16'd0));
         tag = ntag;
         n = nn;
      end
      wait_cap(exp_q.size(), ok);
      repeat (8) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < cap.size()) ? cap[i] : 'x;
         n_tests++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL random word%0d got %h want %h", i, got, exp_q[i]); end
      end
      n_tests++; if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL random count got %0d want %0d", cap.size(), exp_q.size()); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL random busy got %b want 0", busy); end
      seq = seq + 16'd4;
   endtask

   task automatic test_oneshot();
      bit          ok;
      logic [32:0] got;
      logic [7:0]  tag;
      stb_en_reg = '0;
      user_rst = 1'b1;
      tick();
      user_rst = 1'b0;
      seq = '0;
      cap.delete();
      exp_q.delete();
      tag = 8'($urandom);
      stb_en_reg = mk_reg(1'b0, 1'b0, tag, 12'd2);
      tick();
      stb_en_reg = mk_reg(1'b0, 1'b1, tag, 12'd2);
      exp_q.push_back(hdr(tag, 16'd0));
      wait_cap(1, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL oneshot hdr_timeout got %0d words want 1", cap.size()); end
      feed(2, 1'b1, '0);
      exp_q.push_back(trl(16'd0));
      wait_cap(exp_q.size(), ok);
      repeat (10) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < cap.size()) ? cap[i] : 'x;
         n_tests++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL oneshot word%0d got %h want %h", i, got, exp_q[i]); end
      end
      n_tests++; if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL oneshot count got %0d want %0d", cap.size(), exp_q.size()); end
      n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL oneshot pkt_count got %0d want 1", pkt_count); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL oneshot busy got %b want 0", busy); end
      seq = 16'd1;
   endtask

   // ready low for three payload cycles: the held word blocks three samples
   task automatic test_drops();
      bit          ok;
      logic [32:0] got;
      logic [31:0] d;
      logic [7:0]  tag;
      cap.delete();
      exp_q.delete();
      tag = 8'($urandom);
      stb_en_reg = mk_reg(1'b0, 1'b0, tag, 12'd8);
      tick();
      stb_en_reg = mk_reg(1'b0, 1'b1, tag, 12'd8);
      exp_q.push_back(hdr(tag, seq));
      wait_cap(1, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL drops hdr_timeout got %0d words want 1", cap.size()); end
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         out_ready = !(i >= 1 && i <= 3);
         drive(1'b1, i == 0, d);
         if (i == 0 || i >= 4) exp_q.push_back({1'b0, d});
      end
      out_ready = 1'b1;
      drive(1'b0, 1'b0, '0);
      exp_q.push_back(trl(16'd3));
      wait_cap(exp_q.size(), ok);
      repeat (4) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < cap.size()) ? cap[i] : 'x;
         n_tests++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL drops word%0d got %h want %h", i, got, exp_q[i]); end
      end
      n_tests++; if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL drops count got %0d want %0d", cap.size(), exp_q.size()); end
      n_tests++; if (drop_count !== 16'd3) begin n_fail++; $display("FAIL drops drop_count got %0d want 3", drop_count); end
      n_tests++; if (pkt_count !== 16'd2) begin n_fail++; $display("FAIL drops pkt_count got %0d want 2", pkt_count); end
      seq = seq + 16'd1;
   endtask

   task automatic test_zero_len();
      stb_en_reg = mk_reg(1'b1, 1'b0, 8'h11, 12'd0);
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'($urandom), $urandom);
         n_tests++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_len cyc%0d valid/busy got %b want 00", i, {out_valid, busy}); end
      end
      drive(1'b0, 1'b0, '0);
      stb_en_reg = mk_reg(1'b0, 1'b1, 8'h11, 12'd0);
      repeat (2) tick();
      stb_en_reg = mk_reg(1'b0, 1'b1, 8'h11, 12'd4);
      for (int i = 0; i < 6; i++) begin
         tick();
         n_tests++; if ({out_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL zero_len_trig cyc%0d valid/busy got %b want 00", i, {out_valid, busy}); end
      end
      stb_en_reg = '0;
      tick();
   endtask

   task automatic test_reset_mid();
      bit          ok;
      logic [32:0] got;
      logic [7:0]  tag;
      cap.delete();
      exp_q.delete();
      tag = 8'($urandom);
      stb_en_reg = mk_reg(1'b1, 1'b0, tag, 12'd6);
      wait_cap(1, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL reset_mid hdr_timeout got %0d words want 1", cap.size()); end
      drive(1'b1, 1'b1, $urandom);
      drive(1'b1, 1'b0, $urandom);
      in_valid = 1'b0;
      user_rst = 1'b1;
      tick();
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid out_valid got %b want 0", out_valid); end
      n_tests++; if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_mid pkt_count got %0d want 0", pkt_count); end
      n_tests++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_mid drop_count got %0d want 0", drop_count); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid busy got %b want 0", busy); end
      stb_en_reg = '0;
      user_rst = 1'b0;
      tick();
      cap.delete();
      exp_q.delete();
      tag = 8'($urandom);
      stb_en_reg = mk_reg(1'b1, 1'b0, tag, 12'd1);
      exp_q.push_back(hdr(tag, 16'd0));
      wait_cap(1, ok);
      n_tests++; if (!ok) begin n_fail++; $display("FAIL reset_mid hdr0_timeout got %0d words want 1", cap.size()); end
      stb_en_reg = mk_reg(1'b0, 1'b0, tag, 12'd1);
      feed(1, 1'b1, '0);
      exp_q.push_back(trl(16'd0));
      wait_cap(exp_q.size(), ok);
      repeat (6) tick();
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < cap.size()) ? cap[i] : 'x;
         n_tests++;
         if (got !== exp_q[i]) begin n_fail++; $display("FAIL reset_mid word%0d got %h want %h", i, got, exp_q[i]); end
      end
      n_tests++; if (cap.size() != exp_q.size()) begin n_fail++; $display("FAIL reset_mid count got %0d want %0d", cap.size(), exp_q.size()); end
      n_tests++; if (pkt_count !== 16'd1) begin n_fail++; $display("FAIL reset_mid pkt_count got %0d want 1", pkt_count); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired after %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_oneshot();
      test_drops();
      test_zero_len();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/chan_packet_framer.md
# chan_packet_framer

Frames the per-channel sample stream into counted packets under control of the `stb_en` software register word (`user_data_out`, already synchronised to `user_clk`). Sits directly downstream of the `chan_packet_stb_en` register: it decodes enable, one-shot trigger, tag and length fields, and emits header, payload and trailer words to the packet transmit path. Samples that arrive while the output is stalled are dropped and counted; the channelizer stream is never back-pressured.

## Interface
- `DATA_W`, 32: sample and output word width; fixed at 32 for this design.
- `LEN_W`, 12: payload length field width; maximum payload is 4095 words.
- `user_clk`  in  1  sole clock.
- `user_rst`  in  1  synchronous, active-high reset.
- `stb_en_reg`  in  32  register word. Fields:
  - [0] enable (continuous).
  - [1] one-shot trigger (rising edge).
  - [15:8] tag.
  - [27:16] payload length N.
  - All other bits ignored.
- `in_valid`  in  1  sample strobe.
- `in_data`  in  32  sample.
- `in_sync`  in  1  frame start; qualified by `in_valid`.
- `out_valid`  out  1  output word valid.
- `out_data`  out  32  header, payload or trailer word.
- `out_last`  out  1  high on the trailer word only.
- `out_ready`  in  1  downstream accept.
- `busy`  out  1  high in any state other than IDLE.
- `pkt_count`  out  16  packets completed; wraps.
- `drop_count`  out  16  total dropped samples; saturates at 0xFFFF.

## Operation
- One clock and one reset: synchronous, active-high `user_rst` on `user_clk`. Reset state applies on the first edge with `user_rst`=1.
- Reset values:
  - state IDLE.
  - `out_valid`, `out_last`, `busy` = 0.
  - `out_data` = 0.
  - `pkt_count`, `drop_count`, seq = 0.
  - Trigger edge register = 0.
- States: IDLE, HDR, SYNC, PAY, TRL.
- IDLE → HDR when N≠0 and either enable=1 or a rising edge on bit[1] is seen. Entering HDR latches N, tag and mode (continuous/one-shot).
- With N=0 the block stays in IDLE and discards trigger edges.
- HDR: present `{8'hA5, tag, seq[15:0]}`. On accept (`out_valid` & `out_ready`) → SYNC.
- SYNC: wait for `in_valid` & `in_sync`. That sample is payload word 0 → PAY, word counter = 1. When N=1 → TRL instead.
- PAY: every `in_valid` consumes one slot; the value of `in_sync` is ignored.
  - If the output register is empty or is being accepted this cycle, the sample is loaded.
  - Otherwise the sample is dropped: `drop_count`+1 (saturating) and the per-packet drop counter +1.
  - After slot N-1 is consumed → TRL.
- TRL: present `{8'h5A, 8'h00, pkt_drops[15:0]}` with `out_last`=1. This waits until any held payload word has been accepted.
- On trailer accept:
  - `pkt_count`+1 and seq+1.
  - Per-packet drop counter cleared.
  - → HDR if mode is continuous and enable is still 1; otherwise → IDLE.
- Samples arriving in IDLE, HDR, TRL, or in SYNC without sync are ignored. They are not counted as drops.
- Clearing enable mid-packet does not abort: the current packet completes through its trailer, then the block returns to IDLE.
- Register changes mid-packet affect only the next packet.
- A one-shot edge arriving outside IDLE is discarded.

## Timing
- Sample accepted at edge t appears on `out_data` with `out_valid`=1 after edge t+1: one cycle of latency.
- IDLE seeing enable at edge t puts the header valid after edge t+1.
- `out_valid`/`out_data`/`out_last` follow standard valid/ready rules: held stable until accepted; never retracted.
- With `out_ready` held at 1, throughput is one word per cycle. The packet is 1 header + N payload + 1 trailer word.
- HDR → SYNC and TRL → HDR each take a single accept cycle; there are no bubbles beyond the wait for sync.
- Reset mid-packet: the packet is abandoned, `out_valid` is 0 after the reset edge, and no trailer is sent.

## Structure
- Package `chan_packet_pkg` holds:
  - `HDR_MAGIC` = 8'hA5 and `TRL_MAGIC` = 8'h5A.
  - The state enum.
  - Register field bit positions: `EN_BIT`, `TRIG_BIT`, `TAG_LSB`, `LEN_LSB`.
- Sub-module `chan_packet_out_reg`: a one-entry valid/ready output holding register. It exposes load, can-load and accept.
- The FSM, counters and field decode live in the top module.

## Test plan
- Enable=1, N=4, tag=0x3C, `out_ready`=1, sync then 3 more samples (0x10–0x13) → A53C0000, 10, 11, 12, 13, 5A000000 (last). Then the next header A53C0001.
- One-shot: bit[1] 0→1 with N=2 → exactly one packet; `pkt_count`=1; block returns to IDLE. Holding bit[1] high produces no second packet.
- `out_ready` low for 3 cycles during PAY with continuous samples, N=8 → 3 samples dropped; trailer is 5A000003; `drop_count`=3.
- Enable cleared during PAY of packet seq 5 → the packet completes with its trailer; no header with seq 6; `busy` falls after the trailer is accepted.
- N=0 with enable=1 → remains IDLE; `out_valid` stays 0.
- `user_rst` asserted mid-PAY → the next cycle shows `out_valid`=0 and both counters at 0. After re-enable, the first header has seq 0.
